dmem_responder: RTL and testbench

- Data-memory responder: the slave end of the load/store port that the MEM stage drives as initiator.
- Accepts one request at a time over a valid/ready request channel, performs a byte-strobed write or a word read on an internal register array, and returns a response over a valid/ready response channel after a fixed, parameterised latency.
- Sits beside the pipeline top as the MEM stage's memory model. It is used for NPC simulation and as the reference behaviour for a later bus bridge.

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_array.sv | 50 +++++
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared definitions for the data-memory responder slice.
//            Holds the FSM state encoding, the default base address, the
//            default byte-lane count and the byte-strobe merge helper.
// Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // FSM state encoding shared by the responder and any future bridge model
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_WAIT = 2'd1;
    localparam state_t c_ST_RESP = 2'd2;

    // Byte address of word 0 in the default memory map
    localparam logic [31:0] c_BASE_ADDR = 32'h8000_0000;

    // Default data width and the matching byte-lane count
    localparam int c_DATA_W = 64;
    localparam int c_BYTES  = c_DATA_W / 8;

    // Merge new_word into old_word on the lanes selected by strb.
    // Operates on the widest legal word (64 bits / 8 lanes); narrower
    // callers zero-extend their operands and keep the low bits of the result.
    function automatic logic [63:0] strobe_merge(
        input logic [63:0] old_word,
        input logic [63:0] new_word,
        input logic [7:0]  strb
    );
        logic [63:0] merged;
        merged = old_word;
        for (int k = 0; k < 8; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : DEPTH x DATA_W register array with one combinational read port
//            and one synchronous, byte-strobed write port. Contents are not
//            reset.
// Ports    : clk    - write clock (rising edge)
//            raddr  - read word index
//            rdata  - read data (combinational from raddr)
//            we     - write enable
//            waddr  - write word index
//            wdata  - write data
//            wstrb  - per-byte write enables
// Revision : 1.0  initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [63:0]       w_merged;

    // Read-modify-write of the addressed word; only strobed lanes change
    always_comb begin
        w_merged = strobe_merge(64'(r_mem[waddr]), 64'(wdata), 8'(wstrb));
    end

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= w_merged[DATA_W-1:0];
        end
    end

    // Combinational read returns the pre-edge contents during a write edge
    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Slave end of the MEM-stage load/store port. Accepts one request
//            at a time, performs a strobed write or word read on an internal
//            array at the accept edge, and returns the response LATENCY
//            edges later, held until the initiator consumes it.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous reset, active HIGH despite the name
//            req_valid  - request present
//            req_ready  - responder idle and able to accept
//            req_addr   - byte address
//            req_we     - 1 = write, 0 = read
//            req_wdata  - write data
//            req_wstrb  - write byte enables
//            resp_valid - response present
//            resp_ready - initiator consumes response
//            resp_rdata - read data (0 for writes and errors)
//            resp_err   - address out of range
// Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(c_BASE_ADDR),
    parameter int                LATENCY   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_we,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);

    localparam int         c_LANES    = DATA_W / 8;
    localparam int         c_OFF_BITS = $clog2(c_LANES);
    localparam int         c_IDX_W    = $clog2(DEPTH);
    localparam int         c_CNT_W    = 4;
    // WAIT is entered with the count that makes RESP land LATENCY edges
    // after accept: one edge into WAIT, cnt+1 edges to leave it.
    localparam logic [c_CNT_W-1:0] c_CNT_INIT =
        c_CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_accept;
    logic [ADDR_W-1:0]   w_off;
    logic [ADDR_W-1:0]   w_idx_full;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_err;
    logic [DATA_W-1:0]   w_mem_rdata;
    logic                w_mem_we;

    // ------------------------------------------------------------------
    // Address decode. The subtraction may wrap for addresses below the
    // base; the explicit compare catches that case instead.
    // ------------------------------------------------------------------
    assign w_off      = req_addr - BASE_ADDR;
    assign w_idx_full = w_off >> c_OFF_BITS;
    assign w_idx      = w_idx_full[c_IDX_W-1:0];
    assign w_err      = (req_addr < BASE_ADDR) ||
                        (w_idx_full >= ADDR_W'(DEPTH));

    assign w_accept   = req_valid && (r_state == c_ST_IDLE);
    assign w_mem_we   = w_accept && req_we && !w_err;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (c_IDX_W)
    ) u_array (
        .clk   (clk),
        .raddr (w_idx),
        .rdata (w_mem_rdata),
        .we    (w_mem_we),
        .waddr (w_idx),
        .wdata (req_wdata),
        .wstrb (req_wstrb)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = c_ST_RESP;
                    end else begin
                        w_state_nxt = c_ST_WAIT;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end
            end
            c_ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response registers: captured only at the accept edge so they stay
    // stable through WAIT and any backpressure in RESP.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_err   <= w_err;
            r_rdata <= (req_we || w_err) ? '0 : w_mem_rdata;
        end
    end

    assign req_ready  = (r_state == c_ST_IDLE);
    assign resp_valid = (r_state == c_ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. A LATENCY=2 instance is
//            exercised with directed and randomized traffic against a word
//            map model; a LATENCY=1 instance checks the single-edge path.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int          DEPTH  = 1024;
    localparam int          DEPTH1 = 16;
    localparam int          LAT    = 2;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, resp_rdata;
    logic [7:0]  req_wstrb;

    logic        l1_req_valid, l1_req_ready, l1_req_we, l1_resp_valid, l1_resp_ready, l1_resp_err;
    logic [31:0] l1_req_addr;
    logic [63:0] l1_req_wdata, l1_resp_rdata;
    logic [7:0]  l1_req_wstrb;

    int n_vec = 0;
    int n_err = 0;

    // Reference memory: word index -> contents, only for words written so far
    logic [63:0] model [int];

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W(32), .DATA_W(64), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(
        .ADDR_W(32), .DATA_W(64), .DEPTH(DEPTH1), .BASE_ADDR(BASE), .LATENCY(1)
    ) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_addr(l1_req_addr),
        .req_we(l1_req_we), .req_wdata(l1_req_wdata), .req_wstrb(l1_req_wstrb),
        .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
        .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err)
    );

    function automatic bit addr_err(input logic [31:0] a);
        if (a < BASE) return 1'b1;
        return ((a - BASE) / 8) >= DEPTH;
    endfunction

    function automatic int addr_idx(input logic [31:0] a);
        return int'((a - BASE) / 8);
    endfunction

    // Full transaction on the LATENCY=2 instance with bp cycles of backpressure
    task automatic issue(input logic [31:0] a, input logic we, input logic [63:0] wd,
                         input logic [7:0] ws, input int bp, input string name);
        logic [63:0] exp_rd, word;
        logic        exp_err;
        int          idx, lat, n;
        exp_err = addr_err(a);
        idx     = exp_err ? -1 : addr_idx(a);
        exp_rd  = 64'h0;
        if (!we && !exp_err) exp_rd = model.exists(idx) ? model[idx] : 64'h0;
        if (we && !exp_err) begin
            word = model.exists(idx) ? model[idx] : 64'h0;
            for (int k = 0; k < 8; k++) if (ws[k]) word[8*k +: 8] = wd[8*k +: 8];
            model[idx] = word;
        end

        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd; req_wstrb = ws;
        resp_ready = (bp == 0);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        n_vec++;
        if (!req_ready) begin
            n_err++; $display("FAIL %s accept timeout: req_ready=%b required 1", name, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble request fields: they must be ignored outside the accept edge
        req_valid = 1'b0; req_addr = $urandom; req_we = 1'($urandom);
        req_wdata = {$urandom, $urandom}; req_wstrb = 8'($urandom);
        lat = 1;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        n_vec++;
        if (lat !== LAT) begin n_err++; $display("FAIL %s latency: got %0d edges required %0d", name, lat, LAT); end
        n_vec++;
        if (resp_err !== exp_err) begin n_err++; $display("FAIL %s resp_err: got %b required %b", name, resp_err, exp_err); end
        n_vec++;
        if (resp_rdata !== exp_rd) begin n_err++; $display("FAIL %s resp_rdata: got %h required %h", name, resp_rdata, exp_rd); end
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (!(resp_valid === 1'b1 && req_ready === 1'b0 && resp_rdata === exp_rd && resp_err === exp_err)) begin
                n_err++;
                $display("FAIL %s hold: valid=%b ready=%b rdata=%h err=%b required 1 0 %h %b",
                         name, resp_valid, req_ready, resp_rdata, resp_err, exp_rd, exp_err);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL %s handshake: valid=%b ready=%b required 0 1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
        l1_req_valid = 1'b0; l1_req_addr = '0; l1_req_we = 1'b0; l1_req_wdata = '0; l1_req_wstrb = '0;
        l1_resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset req_ready: got %b required 1", req_ready); end
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset resp_valid: got %b required 0", resp_valid); end
        n_vec++; if (resp_rdata !== 64'h0) begin n_err++; $display("FAIL reset resp_rdata: got %h required 0", resp_rdata); end
        n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL reset resp_err: got %b required 0", resp_err); end
        n_vec++; if (l1_req_ready !== 1'b1 || l1_resp_valid !== 1'b0) begin
            n_err++; $display("FAIL reset l1: ready=%b valid=%b required 1 0", l1_req_ready, l1_resp_valid);
        end
    endtask

    task automatic test_write_read;
        issue(BASE + 32'h10, 1'b1, 64'h1122334455667788, 8'hFF, 0, "wr_full");
        issue(BASE + 32'h10, 1'b0, 64'h0, 8'h00, 0, "rd_full");
        issue(BASE + 32'h10, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, "wr_partial");
        issue(BASE + 32'h13, 1'b0, 64'h0, 8'hFF, 0, "rd_partial");
        n_vec++;
        if (model[2] !== 64'h11223344AAAAAAAA) begin
            n_err++; $display("FAIL partial model word: got %h required 11223344aaaaaaaa", model[2]);
        end
    endtask

    task automatic test_out_of_range;
        issue(BASE + 32'((DEPTH-1)*8), 1'b1, {$urandom, $urandom}, 8'hFF, 0, "wr_last");
        issue(32'h7FFF_FFF8, 1'b0, 64'h0, 8'h00, 0, "rd_below");
        issue(BASE + 32'(DEPTH*8), 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 0, "wr_above");
        issue(BASE + 32'((DEPTH-1)*8), 1'b0, 64'h0, 8'h00, 0, "rd_last");
    endtask

    task automatic test_backpressure;
        int n;
        issue(BASE + 32'h18, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, "bp_init");
        @(negedge clk);
        req_valid = 1'b1; req_addr = BASE + 32'h18; req_we = 1'b0; req_wstrb = 8'h00; resp_ready = 1'b0;
        @(posedge clk); #1;
        // Keep a second request (a write) pending through WAIT and RESP
        req_addr = BASE + 32'h20; req_we = 1'b1; req_wdata = 64'hCAFE_F00D_5555_1234; req_wstrb = 8'hFF;
        n = 0;
        while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (!(resp_valid === 1'b1 && req_ready === 1'b0 && resp_rdata === 64'h0123_4567_89AB_CDEF && resp_err === 1'b0)) begin
                n_err++;
                $display("FAIL bp hold %0d: valid=%b ready=%b rdata=%h required 1 0 0123456789abcdef", i, resp_valid, req_ready, resp_rdata);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL bp release: valid=%b ready=%b required 0 1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_vec++;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp next accept: req_ready=%b required 0", req_ready); end
        model[4] = 64'hCAFE_F00D_5555_1234;
        n = 0;
        while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
        n_vec++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'h0 || resp_err !== 1'b0) begin
            n_err++; $display("FAIL bp second resp: valid=%b rdata=%h err=%b required 1 0 0", resp_valid, resp_rdata, resp_err);
        end
        @(posedge clk); #1;
        issue(BASE + 32'h20, 1'b0, 64'h0, 8'h00, 0, "bp_readback");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1; req_addr = BASE + 32'h28; req_we = 1'b1;
        req_wdata = 64'h7777_6666_5555_4444; req_wstrb = 8'hFF; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        model[5] = 64'h7777_6666_5555_4444;   // committed at its accept edge
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_err++; $display("FAIL reset_mid %0d: valid=%b ready=%b required 0 1", i, resp_valid, req_ready);
            end
        end
        issue(BASE + 32'h28, 1'b0, 64'h0, 8'h00, 0, "reset_mid_readback");
    endtask

    task automatic l1_txn(input logic [31:0] a, input logic we, input logic [63:0] wd, input logic [7:0] ws,
                          input logic [63:0] exp_rd, input logic exp_err, input string name);
        int n;
        @(negedge clk);
        l1_req_valid = 1'b1; l1_req_addr = a; l1_req_we = we; l1_req_wdata = wd; l1_req_wstrb = ws;
        l1_resp_ready = 1'b1;
        n = 0;
        while (!l1_req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        l1_req_valid = 1'b0;
        n_vec++;
        if (l1_resp_valid !== 1'b1 || l1_resp_rdata !== exp_rd || l1_resp_err !== exp_err) begin
            n_err++;
            $display("FAIL %s: valid=%b rdata=%h err=%b required 1 %h %b", name, l1_resp_valid, l1_resp_rdata, l1_resp_err, exp_rd, exp_err);
        end
        @(posedge clk); #1;
        n_vec++;
        if (l1_resp_valid !== 1'b0) begin n_err++; $display("FAIL %s done: valid=%b required 0", name, l1_resp_valid); end
    endtask

    task automatic test_latency1;
        l1_txn(BASE + 32'h40, 1'b1, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'h0, 1'b0, "l1_write");
        l1_txn(BASE + 32'h44, 1'b0, 64'h0, 8'h00, 64'hFEDC_BA98_7654_3210, 1'b0, "l1_read");
        l1_txn(BASE + 32'(DEPTH1*8), 1'b0, 64'h0, 8'h00, 64'h0, 1'b1, "l1_oor");
    endtask

    task automatic test_random;
        logic [31:0] a;
        int          sel;
        for (int i = 0; i < 16; i++)
            issue(BASE + 32'(i*8), 1'b1, {$urandom, $urandom}, 8'hFF, 0, "rnd_init");
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = $urandom_range(0, 32'h7FFF_FFFF);
            else if (sel == 1) a = BASE + 32'(DEPTH*8) + $urandom_range(0, 32'h0FFF_FFFF);
            else               a = BASE + 32'($urandom_range(0, 15) * 8) + 32'($urandom_range(0, 7));
            issue(a, 1'($urandom), {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), "rnd");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_latency1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
